// File: rtl/iter_div_pkg.sv
// iter_div_pkg: shared width constants and the operand-magnitude helper for the iterative divider.
package iter_div_pkg;
    localparam int WIDTH = 64;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    // |x| as an unsigned value; |MIN| wraps to MIN, which is its correct unsigned magnitude
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction
endpackage

// File: rtl/iter_div_if.sv
// iter_div_if: request/response bundle between the EX stage (master) and the divider (slave).
//  flush, in_valid, in_a, in_b, in_signed, out_ready : master -> slave
//  in_ready, out_valid, out_quot, out_rem            : slave -> master
interface iter_div_if;
    import iter_div_pkg::*;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    modport master (output flush, in_valid, in_a, in_b, in_signed, out_ready,
                    input  in_ready, out_valid, out_quot, out_rem);
    modport slave  (input  flush, in_valid, in_a, in_b, in_signed, out_ready,
                    output in_ready, out_valid, out_quot, out_rem);
endinterface

// File: rtl/iter_div_step.sv
// iter_div_step: one combinational restoring-division iteration (r,q,b) -> (r',q').
//  r_i/r_o : partial remainder (always < b, so it fits in WIDTH bits between steps)
//  q_i/q_o : dividend bits shifting out / quotient bits shifting in
//  b_i     : divisor magnitude
module iter_div_step
    import iter_div_pkg::*;
(
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    // shifted remainder needs one extra bit so the compare never overflows
    logic [WIDTH:0] sh;
    logic           ge;
    always_comb begin
        sh  = {r_i, q_i[WIDTH-1]};
        ge  = sh >= {1'b0, b_i};
        r_o = ge ? WIDTH'(sh - {1'b0, b_i}) : sh[WIDTH-1:0];
        q_o = {q_i[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring divider with RISC-V M div/rem semantics.
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  dif   : slave side of iter_div_if (request, flush, result handshake)
module iter_div
    import iter_div_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    iter_div_if.slave dif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r, q, b;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic             is_ovf;
    assign is_ovf = dif.in_signed && dif.in_a == MIN_VAL && &dif.in_b;
    iter_div_step u_step (.r_i(r), .q_i(q), .b_i(b), .r_o(r_nxt), .q_o(q_nxt));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            r             <= '0;
            q             <= '0;
            b             <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dif.in_ready  <= 1'b1;
            dif.out_valid <= 1'b0;
            dif.out_quot  <= '0;
            dif.out_rem   <= '0;
        end else if (dif.flush) begin
            state         <= IDLE;
            dif.in_ready  <= 1'b1;
            dif.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dif.in_valid) begin
                    dif.in_ready <= 1'b0;
                    if (dif.in_b == '0) begin
                        dif.out_quot  <= '1;
                        dif.out_rem   <= dif.in_a;
                        dif.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (is_ovf) begin
                        dif.out_quot  <= MIN_VAL;
                        dif.out_rem   <= '0;
                        dif.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        r     <= '0;
                        q     <= mag(dif.in_a, dif.in_signed);
                        b     <= mag(dif.in_b, dif.in_signed);
                        cnt   <= CNT_W'(WIDTH);
                        neg_q <= dif.in_signed && (dif.in_a[WIDTH-1] ^ dif.in_b[WIDTH-1]);
                        neg_r <= dif.in_signed && dif.in_a[WIDTH-1];
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - CNT_W'(1);
                    // last step: apply sign fixup straight into the output registers
                    if (cnt == CNT_W'(1)) begin
                        dif.out_quot  <= neg_q ? -q_nxt : q_nxt;
                        dif.out_rem   <= neg_r ? -r_nxt : r_nxt;
                        dif.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (dif.out_ready) begin
                    dif.out_valid <= 1'b0;
                    dif.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed self-checking bench for iter_div.
module tb_iter_div;
    import iter_div_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    iter_div_if dif ();
    iter_div dut (.clk(clk), .rst_n(rst_n), .dif(dif));
    always #5 clk = ~clk;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s);
        @(negedge clk);
        dif.in_valid  = 1'b1;
        dif.in_a      = a;
        dif.in_b      = b;
        dif.in_signed = s;
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
    endtask
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dif.out_valid && lat < 200);
    endtask
    task automatic take(input string tag);
        @(negedge clk);
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.out_ready = 1'b0;
        check({tag, "_vld_drop"}, 64'(dif.out_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(dif.in_ready), 64'd1);
    endtask
    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] eq, input logic [63:0] er, input int elat);
        int lat;
        start(a, b, s);
        wait_result(lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_quot"}, dif.out_quot, eq);
        check({tag, "_rem"}, dif.out_rem, er);
        take(tag);
    endtask
    initial begin
        int lat;
        logic [63:0] q0, r0;
        logic seen;
        dif.flush = 0; dif.in_valid = 0; dif.in_a = 0; dif.in_b = 0; dif.in_signed = 0; dif.out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(dif.in_ready), 64'd1);
        check("rst_out_valid", 64'(dif.out_valid), 64'd0);
        check("rst_quot", dif.out_quot, 64'd0);
        check("rst_rem", dif.out_rem, 64'd0);
        run("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 65);
        run("s-7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 65);
        run("s7_-2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
        run("uffff_2", ONES, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65);
        run("s5_0", 64'd5, 64'd0, 1'b1, ONES, 64'd5, 1);
        run("u5_0", 64'd5, 64'd0, 1'b0, ONES, 64'd5, 1);
        run("s_ovf", MIN_VAL, ONES, 1'b1, MIN_VAL, 64'd0, 1);
        run("u_ovf", MIN_VAL, ONES, 1'b0, 64'd0, MIN_VAL, 65);
        // backpressure: result held for 10 cycles, a stray request must not disturb it
        start(64'd20, 64'd6, 1'b0);
        wait_result(lat);
        check("bp_lat", 64'(lat), 64'd65);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dif.in_valid = (i == 3);
            dif.in_a = 64'd77;
            dif.in_b = 64'd0;
            @(negedge clk);
            if (dif.out_quot !== 64'd3 || dif.out_rem !== 64'd2 || dif.in_ready !== 1'b0 || dif.out_valid !== 1'b1) seen = 1'b1;
        end
        dif.in_valid = 1'b0;
        check("bp_stable", 64'(seen), 64'd0);
        check("bp_quot", dif.out_quot, 64'd3);
        take("bp");
        repeat (3) @(negedge clk);
        check("bp_no_ghost", 64'(dif.out_valid), 64'd0);
        // flush at BUSY cycle 30
        start(64'd1000, 64'd3, 1'b0);
        repeat (29) @(negedge clk);
        check("fl_busy_rdy", 64'(dif.in_ready), 64'd0);
        dif.flush = 1'b1;
        @(negedge clk);
        dif.flush = 1'b0;
        check("fl_vld", 64'(dif.out_valid), 64'd0);
        check("fl_rdy", 64'(dif.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (dif.out_valid !== 1'b0) seen = 1'b1;
        end
        check("fl_quiet", 64'(seen), 64'd0);
        // flush together with a request in IDLE: not accepted
        dif.flush = 1'b1;
        dif.in_valid = 1'b1;
        dif.in_a = 64'd5;
        dif.in_b = 64'd0;
        @(negedge clk);
        dif.flush = 1'b0;
        dif.in_valid = 1'b0;
        check("fl_idle_rdy", 64'(dif.in_ready), 64'd1);
        check("fl_idle_vld", 64'(dif.out_valid), 64'd0);
        run("u9_3", 64'd9, 64'd3, 1'b0, 64'd3, 64'd0, 65);
        // async reset mid-BUSY after a nonzero result is held in the output registers
        run("u50_7", 64'd50, 64'd7, 1'b0, 64'd7, 64'd1, 65);
        start(64'd123, 64'd4, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_in_ready", 64'(dif.in_ready), 64'd1);
        check("ar_out_valid", 64'(dif.out_valid), 64'd0);
        check("ar_quot", dif.out_quot, 64'd0);
        check("ar_rem", dif.out_rem, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (dif.out_valid !== 1'b0) seen = 1'b1;
        end
        check("ar_quiet", 64'(seen), 64'd0);
        q0 = 64'hFFFF_FFFF_FFFF_FF9C;
        r0 = 64'hFFFF_FFFF_FFFF_FFFE;
        run("s-100_7", q0, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, r0, 65);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
